// File: rtl/ps2_host_pkg.sv
// Shared types and helpers for the PS/2 host controller.
package ps2_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_TX_INHIBIT,
    ST_TX_START,
    ST_TX_BITS,
    ST_TX_ACK,
    ST_TX_RECOVER
  } state_t;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  // Parity bit that makes the total count of ones over data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_ctl_line_filter.sv
// Two-flop synchroniser followed by a glitch filter for one PS/2 line.
// The filtered level only follows the synchronised level after CLK_FILTER
// consecutive disagreeing samples; idles high like the open-drain bus.
module ps2_line_filter #(
  parameter int CLK_FILTER = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_raw,
  output logic line_filt
);

  localparam int CW = (CLK_FILTER > 1) ? $clog2(CLK_FILTER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_FILTER - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // Synchronise the asynchronous pin into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], line_raw};
  end

  // Count consecutive disagreeing samples; flip only after a full run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      line_filt <= 1'b1;
    end else if (sync_q[1] == line_filt) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q     <= '0;
      line_filt <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/ps2_host_ctl.sv
// PS/2 host controller: receives device frames and, when built with
// PS2_HOST_TX_EN defined, transmits host-to-device bytes.
//
// state         | meaning
// --------------+------------------------------------------------------
// ST_IDLE       | bus idle, waiting for start bit or transmit request
// ST_RX         | sampling device frame on each clock fall
// ST_TX_INHIBIT | host holding clock low before a transmit
// ST_TX_START   | data pulled low (start bit), clock released next cycle
// ST_TX_BITS    | presenting data/parity/stop on each device clock fall
// ST_TX_ACK     | waiting for the device ack bit
// ST_TX_RECOVER | waiting for both lines to return high
module ps2_host_ctl
  import ps2_host_pkg::*;
#(
  parameter int CLK_FILTER     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int INHIBIT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_in__clk,
  input  logic       ps2_in__data,
  output logic       ps2_out__clk,
  output logic       ps2_out__data,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_error,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic                  clk_filt, data_filt, clk_prev_q, fall;
  state_t                state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d, frame;
  logic [TW-1:0]         tmo_q;
  logic                  tmo_hit;
  logic [7:0]            rx_data_d;
  logic                  rx_valid_d, rx_error_d;

`ifdef PS2_HOST_TX_EN
  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  logic [INH_W-1:0] inh_q, inh_d;
  logic             out_clk_q, out_clk_d, out_data_q, out_data_d;
  logic             tx_ack_d, tx_done_d, tx_error_d;
`else
  localparam int INHIBIT_UNUSED = INHIBIT_CYCLES;
  logic unused_tx;
  assign unused_tx = ^{tx_req, tx_data};
`endif

  ps2_line_filter #(.CLK_FILTER(CLK_FILTER)) u_filt_clk (
    .clk(clk), .reset_n(reset_n), .line_raw(ps2_in__clk), .line_filt(clk_filt)
  );

  ps2_line_filter #(.CLK_FILTER(CLK_FILTER)) u_filt_data (
    .clk(clk), .reset_n(reset_n), .line_raw(ps2_in__data), .line_filt(data_filt)
  );

  assign fall    = clk_prev_q & ~clk_filt;
  assign frame   = {data_filt, shift_q[FRAME_BITS-1:1]};
  assign tmo_hit = (tmo_q == TMO_LAST);
  assign busy    = (state_q != ST_IDLE);

  // Next-state and pulse decode; pulses are registered so they never overlap.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    rx_error_d = 1'b0;
`ifdef PS2_HOST_TX_EN
    inh_d      = inh_q;
    out_clk_d  = out_clk_q;
    out_data_d = out_data_q;
    tx_ack_d   = 1'b0;
    tx_done_d  = 1'b0;
    tx_error_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // A device start bit wins over a pending transmit request.
        if (fall && !data_filt) begin
          state_d   = ST_RX;
          bit_cnt_d = 4'd1;
          shift_d   = frame;
        end
`ifdef PS2_HOST_TX_EN
        else if (tx_req && clk_filt && !fall) begin
          state_d   = ST_TX_INHIBIT;
          tx_ack_d  = 1'b1;
          out_clk_d = 1'b0;
          inh_d     = INH_LAST;
          shift_d   = {2'b00, odd_parity(tx_data), tx_data};
        end
`endif
      end
      ST_RX: begin
        if (fall) begin
          shift_d   = frame;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
            state_d = ST_IDLE;
            if (!frame[0] && frame[FRAME_BITS-1] &&
                (frame[9] == odd_parity(frame[8:1]))) begin
              rx_data_d  = frame[8:1];
              rx_valid_d = 1'b1;
            end else begin
              rx_error_d = 1'b1;
            end
          end
        end else if (tmo_hit) begin
          state_d    = ST_IDLE;
          rx_error_d = 1'b1;
        end
      end
`ifdef PS2_HOST_TX_EN
      ST_TX_INHIBIT: begin
        if (inh_q == '0) begin
          state_d    = ST_TX_START;
          out_data_d = 1'b0;
        end else begin
          inh_d = inh_q - INH_W'(1);
        end
      end
      ST_TX_START: begin
        state_d   = ST_TX_BITS;
        out_clk_d = 1'b1;
        bit_cnt_d = 4'd0;
      end
      ST_TX_BITS: begin
        if (fall) begin
          if (bit_cnt_q == 4'd9) begin
            state_d    = ST_TX_ACK;
            out_data_d = 1'b1;
          end else begin
            out_data_d = shift_q[0];
            shift_d    = {1'b0, shift_q[FRAME_BITS-1:1]};
            bit_cnt_d  = bit_cnt_q + 4'd1;
          end
        end else if (tmo_hit) begin
          state_d    = ST_TX_RECOVER;
          out_clk_d  = 1'b1;
          out_data_d = 1'b1;
          tx_error_d = 1'b1;
        end
      end
      ST_TX_ACK: begin
        if (fall) begin
          state_d    = ST_TX_RECOVER;
          tx_done_d  = ~data_filt;
          tx_error_d = data_filt;
        end else if (tmo_hit) begin
          state_d    = ST_TX_RECOVER;
          out_clk_d  = 1'b1;
          out_data_d = 1'b1;
          tx_error_d = 1'b1;
        end
      end
      ST_TX_RECOVER: begin
        if (clk_filt && data_filt) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State, frame shifter and receive outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      clk_prev_q <= 1'b1;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      clk_prev_q <= clk_filt;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      rx_error   <= rx_error_d;
    end
  end

  // Fall-to-fall watchdog: cleared on fall or state change, saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          tmo_q <= '0;
    else if (fall || (state_d != state_q)) tmo_q <= '0;
    else if (!tmo_hit)                     tmo_q <= tmo_q + TW'(1);
  end

`ifdef PS2_HOST_TX_EN
  // Line drivers and transmit pulses; reset releases both lines at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inh_q      <= '0;
      out_clk_q  <= 1'b1;
      out_data_q <= 1'b1;
      tx_ack     <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      inh_q      <= inh_d;
      out_clk_q  <= out_clk_d;
      out_data_q <= out_data_d;
      tx_ack     <= tx_ack_d;
      tx_done    <= tx_done_d;
      tx_error   <= tx_error_d;
    end
  end

  assign ps2_out__clk  = out_clk_q;
  assign ps2_out__data = out_data_q;
`else
  assign ps2_out__clk  = 1'b1;
  assign ps2_out__data = 1'b1;
  assign tx_ack        = 1'b0;
  assign tx_done       = 1'b0;
  assign tx_error      = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_ctl.sv
// Bench for ps2_host_ctl: device model on the pins, scoreboard of expected
// output pulses checked by an independent monitor.
module tb_ps2_host_ctl;

  localparam int CLK_FILTER     = 4;
  localparam int TIMEOUT_CYCLES = 400;
  localparam int INHIBIT_CYCLES = 50;
  localparam int HALF           = 30;
  localparam int FALL_LAT       = 2 + CLK_FILTER;

  localparam int EV_RX_VALID = 0;
  localparam int EV_RX_ERROR = 1;
  localparam int EV_TX_ACK   = 2;
  localparam int EV_TX_DONE  = 3;
  localparam int EV_TX_ERROR = 4;

  typedef struct {
    int         kind;
    logic [7:0] data;
    longint     tmin;
    longint     tmax;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_in__clk, ps2_in__data;
  logic       ps2_out__clk, ps2_out__data;
  logic       rx_valid, rx_error, tx_ack, tx_done, tx_error, busy;
  logic [7:0] rx_data;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data = 8'h00;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  longint last_fall_cyc = 0;
  exp_t   exp_q[$];
  exp_t   mon_e;
  logic [4:0] mon_p;
  logic [10:0] sim_f;

  // Open-drain bus: either side can pull a line low.
  assign ps2_in__clk  = dev_clk & ps2_out__clk;
  assign ps2_in__data = dev_data & ps2_out__data;

  ps2_host_ctl #(
    .CLK_FILTER(CLK_FILTER),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .INHIBIT_CYCLES(INHIBIT_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ps2_in__clk(ps2_in__clk), .ps2_in__data(ps2_in__data),
    .ps2_out__clk(ps2_out__clk), .ps2_out__data(ps2_out__data),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
    .tx_req(tx_req), .tx_data(tx_data),
    .tx_ack(tx_ack), .tx_done(tx_done), .tx_error(tx_error),
    .busy(busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] data, input longint tmin, input longint tmax);
    exp_t e;
    e.kind = kind; e.data = data; e.tmin = tmin; e.tmax = tmax;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One device clock period carrying bit b.
  task automatic dev_bit(input logic b);
    dev_data = b;
    wait_cyc(HALF);
    dev_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(HALF);
    dev_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) dev_bit(f[i]);
    dev_data = 1'b1;
    wait_cyc(HALF);
  endtask

  // Device side of a host-to-device transfer; nfalls < 10 abandons the frame.
  task automatic dev_tx(input logic [7:0] d, input bit check_inh, input int nfalls);
    int n;
    logic [9:0] got;
    got = '0;
    @(negedge clk);
    n = 0;
    while (ps2_out__clk !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
    check("inhibit_clk_low", 32'(ps2_out__clk), 32'd0);
    tx_req = 1'b0;
    n = 0;
    while (ps2_out__clk === 1'b0 && n < 4000) begin @(negedge clk); n++; end
    if (check_inh) check("inhibit_len", 32'(n), 32'(INHIBIT_CYCLES + 1));
    wait_cyc(HALF);
    check("tx_start_bit", 32'(ps2_out__data), 32'd0);
    for (int i = 0; i < nfalls; i++) begin
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(HALF);
      dev_clk = 1'b1;
      got[i] = ps2_in__data;
      wait_cyc(HALF);
    end
    if (nfalls == 10) begin
      check("tx_line_bits", 32'(got), 32'({1'b1, ~^d, d}));
      dev_data = 1'b0;
      wait_cyc(10);
      dev_clk = 1'b0;
      wait_cyc(HALF);
      dev_clk = 1'b1;
      wait_cyc(10);
      dev_data = 1'b1;
      n = 0;
      while (busy && n < 500) begin wait_cyc(1); n++; end
      check("tx_busy_clear", 32'(busy), 32'd0);
      check("tx_lines_released", 32'({ps2_out__clk, ps2_out__data}), 32'd3);
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      mon_p = {tx_error, tx_done, tx_ack, rx_error, rx_valid};
      if (mon_p != 5'd0) begin
        check("pulse_onehot", 32'($countones(mon_p)), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: got %b required none (cycle %0d)", mon_p, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_kind", 32'(mon_p), 32'd1 << mon_e.kind);
          if (mon_e.kind == EV_RX_VALID || mon_e.kind == EV_RX_ERROR)
            check("rx_data", 32'(rx_data), 32'(mon_e.data));
          if (mon_e.tmax != 0) begin
            checks++;
            if (cyc < mon_e.tmin || cyc > mon_e.tmax) begin
              failures++;
              $display("FAIL pulse_time: got cycle %0d required %0d..%0d", cyc, mon_e.tmin, mon_e.tmax);
            end
          end
        end
      end
    end
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    int n;
    // reset state
    wait_cyc(3);
    check("rst_out_clk", 32'(ps2_out__clk), 32'd1);
    check("rst_out_data", 32'(ps2_out__data), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_pulses", 32'({rx_valid, rx_error, tx_ack, tx_done, tx_error}), 32'd0);
    reset_n = 1'b1;
    wait_cyc(10);

    // receive: good, bad parity, more patterns
    expect_ev(EV_RX_VALID, 8'h1C, 0, 0);
    send_frame(8'h1C, 1'b0);
    check("rx_1c_data", 32'(rx_data), 32'h1C);
    check("rx_idle_busy", 32'(busy), 32'd0);
    expect_ev(EV_RX_ERROR, 8'h1C, 0, 0);
    send_frame(8'hF0, 1'b1);
    check("rx_data_held", 32'(rx_data), 32'h1C);
    expect_ev(EV_RX_VALID, 8'hA5, 0, 0);
    send_frame(8'hA5, 1'b0);
    expect_ev(EV_RX_VALID, 8'h00, 0, 0);
    send_frame(8'h00, 1'b0);

    // receive timeout after four device clocks
    dev_bit(1'b0); dev_bit(1'b1); dev_bit(1'b0); dev_bit(1'b1);
    dev_data = 1'b1;
    check("rx_partial_busy", 32'(busy), 32'd1);
    expect_ev(EV_RX_ERROR, 8'h00, last_fall_cyc + TIMEOUT_CYCLES, last_fall_cyc + TIMEOUT_CYCLES + FALL_LAT + 20);
    wait_cyc(TIMEOUT_CYCLES + 60);
    check("rx_timeout_idle", 32'(busy), 32'd0);

`ifdef PS2_HOST_TX_EN
    // transmit 0xED with device ack
    expect_ev(EV_TX_ACK, 8'h00, 0, 0);
    expect_ev(EV_TX_DONE, 8'h00, 0, 0);
    tx_data = 8'hED;
    tx_req = 1'b1;
    dev_tx(8'hED, 1'b1, 10);
    wait_cyc(20);

    // transmit abandoned by the device after four clocks
    expect_ev(EV_TX_ACK, 8'h00, 0, 0);
    tx_data = 8'h55;
    tx_req = 1'b1;
    dev_tx(8'h55, 1'b1, 4);
    expect_ev(EV_TX_ERROR, 8'h00, last_fall_cyc + TIMEOUT_CYCLES, last_fall_cyc + TIMEOUT_CYCLES + FALL_LAT + 20);
    wait_cyc(TIMEOUT_CYCLES + 60);
    check("tx_timeout_lines", 32'({ps2_out__clk, ps2_out__data}), 32'd3);
    check("tx_timeout_busy", 32'(busy), 32'd0);

    // request lands in the same cycle as a start-bit fall: receive first
    expect_ev(EV_RX_VALID, 8'h3A, 0, 0);
    expect_ev(EV_TX_ACK, 8'h00, 0, 0);
    expect_ev(EV_TX_DONE, 8'h00, 0, 0);
    sim_f = {1'b1, ~^8'h3A, 8'h3A, 1'b0};
    dev_data = 1'b0;
    wait_cyc(HALF);
    dev_clk = 1'b0;
    wait_cyc(FALL_LAT);
    tx_data = 8'h12;
    tx_req = 1'b1;
    wait_cyc(HALF - FALL_LAT);
    dev_clk = 1'b1;
    for (int i = 1; i < 11; i++) dev_bit(sim_f[i]);
    dev_data = 1'b1;
    wait_cyc(HALF);
    dev_tx(8'h12, 1'b0, 10);
    wait_cyc(20);

    // asynchronous reset in the middle of the data bits
    expect_ev(EV_TX_ACK, 8'h00, 0, 0);
    tx_data = 8'h99;
    tx_req = 1'b1;
    dev_tx(8'h99, 1'b0, 3);
    check("mid_tx_data_low", 32'(ps2_out__data), 32'd0);
    check("mid_tx_busy", 32'(busy), 32'd1);
    #4;
    reset_n = 1'b0;
    #1;
    check("arst_out_lines", 32'({ps2_out__clk, ps2_out__data}), 32'd3);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pulses", 32'({rx_valid, rx_error, tx_ack, tx_done, tx_error}), 32'd0);
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(50);
    check("post_rst_busy", 32'(busy), 32'd0);
`else
    // transmit path absent: requests are ignored, lines never driven
    tx_data = 8'hED;
    tx_req = 1'b1;
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_ack || tx_done || tx_error || !ps2_out__clk || !ps2_out__data) n++;
    end
    check("notx_quiet", 32'(n), 32'd0);
    expect_ev(EV_RX_VALID, 8'h5A, 0, 0);
    send_frame(8'h5A, 1'b0);
    check("notx_rx_data", 32'(rx_data), 32'h5A);
    tx_req = 1'b0;
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin wait_cyc(1); n++; end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    wait_cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_host_ctl.md
PS2_HOST_CTL -- requirements
Module: ps2_host_ctl

Interface
REQ-001 SHALL have parameter CLK_FILTER, default 8: consecutive equal clk samples needed to change a filtered PS/2 line.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: maximum clk cycles between device clock falling edges within a frame (2 ms at 50 MHz).
REQ-003 SHALL have parameter INHIBIT_CYCLES, default 5000: duration the host holds clock low before transmitting (100 us).
REQ-004 clk  in  1  system clock, 50 MHz; one clock, no other clock domains.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ps2_in__clk  in  1  raw PS/2 clock pin level (asynchronous).
REQ-007 ps2_in__data  in  1  raw PS/2 data pin level (asynchronous).
REQ-008 ps2_out__clk  out  1  1 = release (high-Z), 0 = drive clock low.
REQ-009 ps2_out__data  out  1  1 = release (high-Z), 0 = drive data low.
REQ-010 rx_valid  out  1  one-cycle pulse, rx_data valid.
REQ-011 rx_data  out  8  last received byte, held until next rx_valid.
REQ-012 rx_error  out  1  one-cycle pulse: framing, parity or timeout error on receive.
REQ-013 tx_req  in  1  level request to send tx_data.
REQ-014 tx_data  in  8  byte to send, sampled on the tx_ack cycle.
REQ-015 tx_ack  out  1  one-cycle pulse, request accepted and tx_data latched.
REQ-016 tx_done  out  1  one-cycle pulse, device acknowledged the byte.
REQ-017 tx_error  out  1  one-cycle pulse: no device ack, or timeout during transmit.
REQ-018 busy  out  1  high in every state other than IDLE.

Function
REQ-019 Each input SHALL pass through a 2-flop synchroniser, then a filter that changes level only after CLK_FILTER consecutive agreeing samples; a 1-to-0 change of the filtered clock is a "fall" event.
REQ-020 State machine states: IDLE, RX, TX_INHIBIT, TX_START, TX_BITS, TX_ACK, TX_RECOVER.
REQ-021 IDLE->RX on a fall event with filtered data 0 (start bit); RX SHALL sample filtered data on each fall event: 8 data bits LSB first, odd parity, stop bit.
REQ-022 On the 11th sample, a valid frame (start 0, odd parity over data+parity, stop 1) SHALL load rx_data and pulse rx_valid on the next cycle; otherwise it SHALL pulse rx_error; either case returns to IDLE.
REQ-023 RX SHALL pulse rx_error and return to IDLE if TIMEOUT_CYCLES elapse without a fall event.
REQ-024 IDLE->TX_INHIBIT only when tx_req=1, filtered clock=1 and no fall event this cycle; a simultaneous fall event with data 0 SHALL take RX, and tx_req remains pending.
REQ-025 TX_INHIBIT SHALL drive clock low for INHIBIT_CYCLES, then enter TX_START, drive data low and release clock one cycle later.
REQ-026 TX_BITS SHALL change ps2_out__data on each fall event: data bits LSB first, odd parity, then release (stop); after the stop fall event it enters TX_ACK.
REQ-027 TX_ACK SHALL sample filtered data on the next fall event: 0 pulses tx_done, 1 pulses tx_error; then TX_RECOVER waits for filtered clock=1 and data=1, then IDLE.
REQ-028 Any TX state from TX_START through TX_ACK that sees no fall event within TIMEOUT_CYCLES SHALL release both lines, pulse tx_error and enter TX_RECOVER.
REQ-029 The timeout counter SHALL reset on every fall event and on every state change, and SHALL saturate rather than wrap.
REQ-030 At most one of rx_valid, rx_error, tx_done, tx_error SHALL be high in any cycle.

Reset
REQ-031 When reset_n=0, the state SHALL be IDLE, ps2_out__clk=1, ps2_out__data=1, all pulse outputs 0, busy=0, rx_data=0, filtered lines=1, and counters 0.
REQ-032 Reset mid-frame SHALL release both lines immediately (asynchronously), with no partial rx_valid or tx_done.

Configuration
REQ-033 With PS2_HOST_TX_EN defined, the transmit path (REQ-024..REQ-028) SHALL be present.
REQ-034 Without PS2_HOST_TX_EN, the TX states and registers SHALL be absent, tx_req and tx_data ignored, tx_ack/tx_done/tx_error tied 0, and ps2_out__clk/ps2_out__data tied 1; receive is unchanged.

Structure
REQ-035 Package ps2_host_pkg SHALL hold the state enumeration, the frame length constant (11) and the odd-parity function.
REQ-036 Sub-module ps2_line_filter (synchroniser + CLK_FILTER filter) SHALL be instantiated once per input line.

Verification
REQ-037 Device sends 0x1C with correct parity at a 12.5 kHz clock -> exactly one rx_valid, rx_data=0x1C, no rx_error.
REQ-038 Device sends 0xF0 with wrong parity -> one rx_error, no rx_valid, rx_data keeps its previous value.
REQ-039 tx_req with tx_data=0xED, and the device model acks -> tx_ack, clock low for 5000 cycles, bits on the line 1,0,1,1,0,1,1,1, parity 1 -> tx_done, busy falls after lines return high.
REQ-040 Device stops clocking after 4 bits during RX -> rx_error 100000 cycles after the last fall event; during TX -> tx_error, both lines released.
REQ-041 tx_req asserted in the same cycle as a device start-bit fall event -> receive completes first (rx_valid), then the transmit starts.
REQ-042 reset_n pulsed low during TX_BITS -> ps2_out__clk=1 and ps2_out__data=1 in the same cycle, no pulses, busy=0; also run the build without PS2_HOST_TX_EN and confirm the tx outputs stay 0.
